// File: rtl/disp_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : disp_mux_scheduler
// Brief    : Select sequencer for the 32-bit 16:1 display/debug source mux.
//            Manual mode passes the switch index through. Auto mode scans the
//            enabled channels and holds each one for DWELL clock cycles.
//            Optional macro DISP_SCAN_REV_EN adds a 'dir' input that selects
//            a descending scan.
// Revision : 1.0 - initial release
// ============================================================================
module disp_mux_scheduler #(
  parameter int unsigned DWELL   = 25_000_000,
  parameter int unsigned DWELL_W = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [3:0]  man_sel,
  input  logic [15:0] ch_mask,
  input  logic        step,
  input  logic        hold,
`ifdef DISP_SCAN_REV_EN
  input  logic        dir,
`endif
  output logic [3:0]  s,
  output logic        ch_valid,
  output logic        wrap
);

  // Dwell counter value on which the held channel is released.
  localparam logic [DWELL_W-1:0] TERM_CNT = DWELL_W'(DWELL - 1);

  logic [3:0]         s_q,    s_d;
  logic [DWELL_W-1:0] cnt_q,  cnt_d;
  logic               wrap_q, wrap_d;

  logic               any_en;
  logic               at_term;
  logic               advance;
  logic               search_desc;
  logic [3:0]         next_ch;
  logic               next_wraps;

  assign any_en  = |ch_mask;
  assign at_term = (cnt_q == TERM_CNT);

  // With an empty mask there is nowhere to go, so neither the terminal
  // count nor step may move the select.
  assign advance = mode && any_en && ((at_term && !hold) || step);

`ifdef DISP_SCAN_REV_EN
  assign search_desc = dir;
`else
  assign search_desc = 1'b0;
`endif

  // Circular search for the next enabled channel; offset 16 lands back on
  // s itself so a single enabled channel re-selects itself.
  always_comb begin
    logic       hit;
    logic [3:0] idx;
    hit     = 1'b0;
    idx     = s_q;
    next_ch = s_q;
    for (int k = 1; k <= 16; k++) begin
      if (search_desc) begin
        idx = s_q - 4'(k);
      end else begin
        idx = s_q + 4'(k);
      end
      if (!hit && ch_mask[idx]) begin
        hit     = 1'b1;
        next_ch = idx;
      end
    end
  end

  // Wrap means the search crossed the end of the index range (or came back
  // to the same channel) in the current scan direction.
  always_comb begin
    next_wraps = 1'b0;
    if (search_desc) begin
      next_wraps = (next_ch >= s_q);
    end else begin
      next_wraps = (next_ch <= s_q);
    end
  end

  // Next-state for select, dwell counter and wrap pulse.
  always_comb begin
    s_d    = s_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (!mode) begin
      s_d   = man_sel;
      cnt_d = '0;
    end else if (!any_en) begin
      cnt_d = '0;
    end else if (advance) begin
      s_d    = next_ch;
      cnt_d  = '0;
      wrap_d = next_wraps;
    end else if (!hold) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset restarts the scan at channel 0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= 4'd0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign s        = s_q;
  assign wrap     = wrap_q;
  assign ch_valid = ch_mask[s_q];

endmodule
`default_nettype wire

// File: tb/tb_disp_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_mux_scheduler
// Brief    : Scoreboard bench for disp_mux_scheduler with DWELL=4. Stimulus
//            pushes the expected post-edge select/wrap/ch_valid per cycle;
//            a monitor pops and compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_mux_scheduler;

  localparam int unsigned DWELL   = 4;
  localparam int unsigned DWELL_W = 4;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [3:0]  man_sel;
  logic [15:0] ch_mask;
  logic        step;
  logic        hold;
`ifdef DISP_SCAN_REV_EN
  logic        dir;
`endif
  logic [3:0]  s;
  logic        ch_valid;
  logic        wrap;

  typedef struct {
    logic [3:0] s;
    logic       wrap;
    logic       cv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  disp_mux_scheduler #(
    .DWELL   (DWELL),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .man_sel  (man_sel),
    .ch_mask  (ch_mask),
    .step     (step),
    .hold     (hold),
`ifdef DISP_SCAN_REV_EN
    .dir      (dir),
`endif
    .s        (s),
    .ch_valid (ch_valid),
    .wrap     (wrap)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Direct (non-scoreboard) check used for asynchronous reset behaviour.
  task automatic check_now(input string nm, input logic [3:0] es, input logic ew);
    n_cmp++;
    if (s !== es || wrap !== ew) begin
      n_bad++;
      $display("FAIL %s: got s=%0d wrap=%0b, expected s=%0d wrap=%0b", nm, s, wrap, es, ew);
    end
  endtask

  // Drive one cycle of inputs and queue the values expected after the edge.
  task automatic drive(input logic m, input logic [3:0] ms, input logic [15:0] mk,
                       input logic st, input logic hd,
                       input logic [3:0] es, input logic ew, input string nm);
    exp_t e;
    @(negedge clk);
    mode    = m;
    man_sel = ms;
    ch_mask = mk;
    step    = st;
    hold    = hd;
    e.s     = es;
    e.wrap  = ew;
    e.cv    = mk[es];
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compare after each rising edge whenever an expectation waits.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (s !== e.s || wrap !== e.wrap || ch_valid !== e.cv) begin
          n_bad++;
          $display("FAIL %s: got s=%0d wrap=%0b ch_valid=%0b, expected s=%0d wrap=%0b ch_valid=%0b",
                   nm, s, wrap, ch_valid, e.s, e.wrap, e.cv);
        end
      end
    end
  end

  initial begin
    logic [3:0] seq [4];
    logic [3:0] es;
    seq[0] = 4'd0; seq[1] = 4'd5; seq[2] = 4'd10; seq[3] = 4'd15;
    rst = 1'b1; mode = 1'b0; man_sel = 4'd0; ch_mask = 16'h0000;
    step = 1'b0; hold = 1'b0;
`ifdef DISP_SCAN_REV_EN
    dir = 1'b0;
`endif
    #3;
    check_now("reset_state", 4'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Manual mode: one-cycle latency, mask does not restrict s.
    drive(1'b0, 4'd9, 16'h0000, 1'b0, 1'b0, 4'd9, 1'b0, "manual_9");
    drive(1'b0, 4'd3, 16'h0008, 1'b0, 1'b0, 4'd3, 1'b0, "manual_3");
    drive(1'b0, 4'd3, 16'h0000, 1'b1, 1'b1, 4'd3, 1'b0, "manual_ign_step");

    // Asynchronous reset between edges, released before the next edge.
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, "after_rst_pulse");
    #2 rst = 1'b1;
    #1 check_now("rst_async_mid_cycle", 4'd0, 1'b0);
    #1 rst = 1'b0;

    // Full scan: advance every 4 edges, one wrap pulse on 15->0.
    for (int e = 0; e < 68; e++) begin
      es = 4'(((e + 1) / 4) % 16);
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, es, (e == 63), "full_scan");
    end

    // Back to manual at channel 0, then sparse mask scan.
    drive(1'b0, 4'd0, 16'h8421, 1'b0, 1'b0, 4'd0, 1'b0, "to_manual");
    for (int e = 0; e < 28; e++) begin
      es = seq[((e + 1) / 4) % 4];
      drive(1'b1, 4'd0, 16'h8421, 1'b0, 1'b0, es, (e == 15), "sparse_scan");
    end

    // Single channel 4 from s=15: 15->4 wraps, then 4->4 wraps.
    for (int e = 0; e < 8; e++) begin
      es = (e < 3) ? 4'd15 : 4'd4;
      drive(1'b1, 4'd0, 16'h0010, 1'b0, 1'b0, es, (e == 3 || e == 7), "single_ch");
    end

    // Hold freezes the counter at 2; after release, advance in 2 edges.
    for (int e = 0; e < 2; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd4, 1'b0, "pre_hold");
    for (int e = 0; e < 10; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 4'd4, 1'b0, "hold");
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd4, 1'b0, "hold_release");
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd5, 1'b0, "hold_resume_adv");

    // Step during hold gives exactly one advance.
    for (int e = 0; e < 2; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 4'd5, 1'b0, "hold2");
    drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 1'b1, 4'd6, 1'b0, "step_in_hold");
    for (int e = 0; e < 2; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b1, 4'd6, 1'b0, "after_step");

    // Step coincident with terminal count: one channel only.
    for (int e = 0; e < 3; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd6, 1'b0, "dwell_to_term");
    drive(1'b1, 4'd0, 16'hFFFF, 1'b1, 1'b0, 4'd7, 1'b0, "step_at_term");
    for (int e = 0; e < 3; e++)
      drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd7, 1'b0, "post_term_dwell");
    drive(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd8, 1'b0, "post_term_adv");

    // Empty mask: select frozen, no wrap, ch_valid low, step ignored.
    for (int e = 0; e < 20; e++)
      drive(1'b1, 4'd0, 16'h0000, (e == 10), 1'b0, 4'd8, 1'b0, "empty_mask");

    // Channel 0 restored: counter restarts from 0, wrap on 8->0.
    for (int e = 0; e < 4; e++) begin
      es = (e < 3) ? 4'd8 : 4'd0;
      drive(1'b1, 4'd0, 16'h0001, 1'b0, 1'b0, es, (e == 3), "mask_restore");
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/disp_mux_scheduler.md
Name: disp_mux_scheduler

Overview:
Sequencer for the 32-bit 16:1 display/debug source mux. It generates the 4-bit select that picks which of 16 datapath words is shown. In manual mode, the select comes from the switches. In auto mode, it scans the enabled channels, holding each one for a programmable dwell time. It sits between the board switch inputs and the mux select, and owns all select timing.

Parameters:
DWELL, 25_000_000, clock cycles each channel is held in auto mode; legal range 1..2^DWELL_W-1.
DWELL_W, 25, width of the dwell counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
mode  in  1  0 = manual select, 1 = auto scan
man_sel  in  4  manual channel index
ch_mask  in  16  channel enable; bit i enables channel i for scanning
step  in  1  single-cycle pulse, synchronous to clk; forces an immediate advance in auto mode
hold  in  1  freezes the dwell counter in auto mode
s  out  4  registered mux select
ch_valid  out  1  current channel enabled: ch_mask[s]; combinational
wrap  out  1  registered one-cycle pulse when the scan wraps

Behaviour:
- Reset (async, rst=1):
  - s=0, dwell counter cnt=0, wrap=0.
  - Applies immediately, including mid-dwell; scanning restarts from channel 0 after release.
- Manual mode (mode=0):
  - s <= man_sel every clock; 1-cycle latency.
  - cnt held at 0; wrap=0; step and hold ignored.
  - ch_mask does not restrict s; ch_valid still reports ch_mask[s].
- Auto mode (mode=1), dwell counter:
  - cnt counts 0..DWELL-1 while hold=0.
  - An advance event occurs when (cnt==DWELL-1 and hold=0) or step=1.
  - On an advance event, cnt <= 0.
  - step and terminal count in the same cycle produce exactly one advance.
  - hold=1 freezes cnt; step still advances while held (single-step debugging).
- Next-channel search (combinational, circular):
  - Find the first enabled channel at index (s+1), (s+2), ... mod 16, up to and including s itself.
  - On advance: s <= found index.
  - wrap <= 1 for one cycle iff found index <= current s. This includes a single enabled channel that re-selects itself, and the 15->0 transition.
  - Otherwise wrap <= 0.
- All-zero mask in auto mode: no advance, s holds, wrap=0, cnt held at 0, ch_valid=0.
- Mask change:
  - Takes effect at the next advance only; s is not moved early.
  - ch_valid drops immediately if the current channel is disabled.
- Mode switching:
  - Manual->auto: the scan continues from the current s with cnt=0; first advance after DWELL cycles.
  - Auto->manual: s follows man_sel on the next clock; cnt cleared.
- DWELL=1: advances every cycle with hold=0.

Optional Feature:
Macro: DISP_SCAN_REV_EN.
- Defined:
  - Adds input port dir (1 bit).
  - dir=1 searches descending: (s-1), (s-2), ... mod 16.
  - Descending wrap pulses iff found index >= current s.
  - dir is sampled at each advance; changing dir mid-dwell does not reset cnt.
- Undefined: no dir port; ascending search only; behaviour exactly as above.

Test Plan:
- Reset/manual: assert rst mid-cycle -> s=0, wrap=0 with no clock edge; release, mode=0, man_sel=9 -> s=9 one clock later; man_sel=3 -> s=3 next clock.
- Full scan (DWELL=4, mode=1, mask=FFFF): s steps 0,1,...,15 every 4 cycles; 15->0 gives wrap=1 for exactly one cycle; no other wrap pulses.
- Sparse mask (mask=8421): sequence 0,5,10,15,0; wrap only on 15->0. Then mask=0010 with s=15 -> next advance s=4 with wrap=1 (4<15); following advance 4->4 with wrap=1.
- Step/hold (DWELL=4): hold=1 for 10 cycles -> s unchanged, cnt frozen; step pulse during hold -> single advance. Step coincident with terminal count -> advance by one channel only.
- Empty mask: mask=0000 in auto -> s constant, ch_valid=0, wrap=0 over 20 cycles. Mask=0001 restored -> s=0 at next advance with wrap=1.
- Reverse (DISP_SCAN_REV_EN, dir=1, mask=FFFF, s=2): sequence 1,0,15 with wrap=1 on 0->15; async rst mid-dwell -> s=0, cnt restarts.
